// File: rtl/point_cloud_writer_pkg.sv
// Shared definitions for the point-cloud writer: ZBT0 word layout and FSM encoding.
package point_cloud_writer_pkg;

  localparam int ZBT_W   = 36;
  localparam int FIELD_W = 10;
  localparam int X_LSB   = 20;
  localparam int Y_LSB   = 10;
  localparam int Z_LSB   = 0;
  localparam int PT_W    = 3 * FIELD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FULL   = 2'd3
  } wr_state_e;

  function automatic logic [ZBT_W-1:0] pack_point(input logic [FIELD_W-1:0] x,
                                                  input logic [FIELD_W-1:0] y,
                                                  input logic [FIELD_W-1:0] z);
    logic [ZBT_W-1:0] word;
    word                    = '0;
    word[X_LSB +: FIELD_W]  = x;
    word[Y_LSB +: FIELD_W]  = y;
    word[Z_LSB +: FIELD_W]  = z;
    return word;
  endfunction

endpackage

// File: rtl/point_cloud_writer_fifo.sv
// Synchronous point buffer with registered full/empty flags and a flush that
// overrides any push or pop in the same cycle.
module point_fifo
  import point_cloud_writer_pkg::*;
#(
  parameter int WIDTH = PT_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_en;
  logic             pop_en;

  assign push_en = push & ~full_q & ~flush;
  assign pop_en  = pop & ~empty_q & ~flush;

  // pointer/occupancy next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == (PTR_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // storage array, no reset so it maps onto plain RAM/flops
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/point_cloud_writer.sv
// Scan-point writer: buffers (x,y,z) points and packs them into sequential ZBT0
// words, publishing the last written index as the renderer's wrap limit.
module point_cloud_writer
  import point_cloud_writer_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int COORD_W    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_start,
  input  logic                scan_done,
  input  logic                pt_valid,
  output logic                pt_ready,
  input  logic [COORD_W-1:0]  pt_x,
  input  logic [COORD_W-1:0]  pt_y,
  input  logic [COORD_W-1:0]  pt_z,
  input  logic                zbt_wr_grant,
  output logic [ADDR_W-1:0]   zbt0_write_addr,
  output logic [35:0]         zbt0_write_data,
  output logic                zbt0_we,
  output logic [ADDR_W-1:0]   max_zbt_addr,
  output logic [ADDR_W:0]     point_count,
  output logic                writer_active,
  output logic                overflow
);

  localparam int PT_BITS = 3 * COORD_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  wr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0]  max_q, max_d;
  logic               ovf_q, ovf_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ZBT_W-1:0]   data_q, data_d;
  logic               we_q, we_d;
  logic               active_q, active_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PT_BITS-1:0] fifo_wdata;
  logic [PT_BITS-1:0] fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic               grant_write;
  logic [ADDR_W-1:0]  publish_idx;

  point_fifo #(
    .WIDTH (PT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ready comes only from registered state and the registered full flag
  always_comb begin
    pt_ready = 1'b0;
    case (state_q)
      ST_ACTIVE: pt_ready = ~fifo_full;
      ST_FULL:   pt_ready = 1'b1;
      default:   pt_ready = 1'b0;
    endcase
  end

  assign fifo_wdata  = {pt_x, pt_y, pt_z};
  assign fifo_push   = pt_valid & pt_ready & ~fifo_flush;
  assign grant_write = ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN)) &&
                       !fifo_empty && zbt_wr_grant;
  assign publish_idx = (count_q == '0) ? '0 : (count_q[ADDR_W-1:0] - ADDR_W'(1));

  // scan FSM, write port and publish logic
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    max_d      = max_q;
    ovf_d      = ovf_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    if (scan_start) begin
      state_d    = ST_ACTIVE;
      wr_ptr_d   = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      fifo_flush = 1'b1;
    end else begin
      case (state_q)
        ST_ACTIVE, ST_DRAIN: begin
          if (grant_write) begin
            fifo_pop = 1'b1;
            we_d     = 1'b1;
            addr_d   = wr_ptr_q;
            data_d   = pack_point(fifo_rdata[2*COORD_W +: COORD_W],
                                  fifo_rdata[COORD_W +: COORD_W],
                                  fifo_rdata[0 +: COORD_W]);
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_q + (ADDR_W+1)'(1);
          end else begin
            we_d = 1'b0;
          end
          // last slot written: the scan cannot continue without wrapping onto index 0
          if (grant_write && (wr_ptr_q == LAST_ADDR)) begin
            if ((state_q == ST_DRAIN) || scan_done) begin
              state_d    = ST_IDLE;
              max_d      = LAST_ADDR;
              fifo_flush = 1'b1;
              ovf_d      = ovf_q | (fifo_count > CNT_W'(1)) | (pt_valid & pt_ready);
            end else begin
              state_d = ST_FULL;
              ovf_d   = 1'b1;
            end
          end else if ((state_q == ST_ACTIVE) && scan_done) begin
            state_d = ST_DRAIN;
          end else if ((state_q == ST_DRAIN) && fifo_empty) begin
            state_d = ST_IDLE;
            max_d   = publish_idx;
          end else begin
            state_d = state_q;
          end
        end
        ST_FULL: begin
          fifo_flush = 1'b1;
          if (scan_done) begin
            state_d = ST_IDLE;
            max_d   = LAST_ADDR;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    active_d = (state_d != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      active_q <= active_d;
    end
  end

  assign zbt0_write_addr = addr_q;
  assign zbt0_write_data = data_q;
  assign zbt0_we         = we_q;
  assign max_zbt_addr    = max_q;
  assign point_count     = count_q;
  assign writer_active   = active_q;
  assign overflow        = ovf_q;

endmodule
